ntt_stage_ctrl: RTL and testbench

//  Sequencer for one butterfly core (1-cycle registered multiply, combinational mod-reduce output).

---
 rtl/ntt_stage_ctrl_if.sv | 31 +++
 rtl/ntt_stage_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ntt_stage_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_ctrl_if.sv
// Handshake and memory-address bundle between the host, the NTT stage sequencer
// and the coefficient RAM / twiddle ROM / butterfly core.
interface ntt_stage_ctrl_if #(
  parameter int N_LOG = 10
);
  logic             start;
  logic             busy;
  logic             done;
  logic [N_LOG-1:0] stage;
  logic             rd_en;
  logic [N_LOG-1:0] rd_addr_a;
  logic [N_LOG-1:0] rd_addr_b;
  logic [N_LOG-1:0] tw_addr;
  logic             wr_en;
  logic [N_LOG-1:0] wr_addr_a;
  logic [N_LOG-1:0] wr_addr_b;

  // host / datapath side
  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );

  // sequencer side
  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// Stage/butterfly sequencer for an in-place Cooley-Tukey NTT on a single
// butterfly core: read addresses per butterfly, write-back after PIPE_LAT cycles.
module ntt_stage_ctrl #(
  parameter int N_LOG    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  ntt_stage_ctrl_if.slave   bus
);

  localparam int CW          = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int LAST_S_I    = N_LOG - 1;
  localparam int LAST_K_I    = (1 << (N_LOG - 1)) - 1;
  localparam int DRAIN_END_I = PIPE_LAT - 1;

  localparam logic [N_LOG-1:0] LAST_S    = LAST_S_I[N_LOG-1:0];
  localparam logic [N_LOG-1:0] LAST_K    = LAST_K_I[N_LOG-1:0];
  localparam logic [N_LOG-1:0] ONE       = {{(N_LOG-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    DRAIN_END = DRAIN_END_I[CW-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [N_LOG-1:0] s_r;
  logic [N_LOG-1:0] k_r;
  logic [CW-1:0]    drain_r;
  logic             busy_r;
  logic             done_r;
  logic [N_LOG-1:0] stage_r;
  logic             rd_en_r;
  logic [N_LOG-1:0] rd_addr_a_r;
  logic [N_LOG-1:0] rd_addr_b_r;
  logic [N_LOG-1:0] tw_addr_r;

  logic [PIPE_LAT-1:0] wr_en_pipe_r;
  logic [N_LOG-1:0]    wr_a_pipe_r [PIPE_LAT];
  logic [N_LOG-1:0]    wr_b_pipe_r [PIPE_LAT];

  // {addr_a, addr_b, tw} for butterfly k of stage s; half = N >> (s+1) = 1 << sh
  function automatic logic [3*N_LOG-1:0] bfly_addr(input logic [N_LOG-1:0] s,
                                                   input logic [N_LOG-1:0] k);
    logic [N_LOG-1:0] sh;
    logic [N_LOG-1:0] half;
    logic [N_LOG-1:0] g;
    logic [N_LOG-1:0] j;
    logic [N_LOG-1:0] a;
    sh   = LAST_S - s;
    half = ONE << sh;
    g    = k >> sh;
    j    = k & (half - ONE);
    a    = (g << (sh + ONE)) | j;
    return {a, a + half, (ONE << s) + g};
  endfunction

  // Stage FSM; outputs are loaded together with the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      s_r         <= '0;
      k_r         <= '0;
      drain_r     <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      stage_r     <= '0;
      rd_en_r     <= 1'b0;
      rd_addr_a_r <= '0;
      rd_addr_b_r <= '0;
      tw_addr_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_RUN;
            s_r     <= '0;
            k_r     <= '0;
            busy_r  <= 1'b1;
            stage_r <= '0;
            rd_en_r <= 1'b1;
            {rd_addr_a_r, rd_addr_b_r, tw_addr_r} <= bfly_addr('0, '0);
          end
        end
        ST_RUN: begin
          if (k_r == LAST_K) begin
            state_r <= ST_DRAIN;
            drain_r <= '0;
            rd_en_r <= 1'b0;
          end else begin
            k_r     <= k_r + ONE;
            {rd_addr_a_r, rd_addr_b_r, tw_addr_r} <= bfly_addr(s_r, k_r + ONE);
          end
        end
        ST_DRAIN: begin
          // hold off the next stage until its inputs have been written back
          if (drain_r != DRAIN_END) begin
            drain_r <= drain_r + 1'b1;
          end else if (s_r != LAST_S) begin
            state_r <= ST_RUN;
            s_r     <= s_r + ONE;
            k_r     <= '0;
            stage_r <= s_r + ONE;
            rd_en_r <= 1'b1;
            {rd_addr_a_r, rd_addr_b_r, tw_addr_r} <= bfly_addr(s_r + ONE, '0);
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          stage_r <= '0;
          s_r     <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          stage_r <= '0;
          rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line: the read strobe and address pair, PIPE_LAT cycles late
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_pipe_r <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_a_pipe_r[i] <= '0;
        wr_b_pipe_r[i] <= '0;
      end
    end else begin
      wr_en_pipe_r[0] <= rd_en_r;
      wr_a_pipe_r[0]  <= rd_addr_a_r;
      wr_b_pipe_r[0]  <= rd_addr_b_r;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_en_pipe_r[i] <= wr_en_pipe_r[i-1];
        wr_a_pipe_r[i]  <= wr_a_pipe_r[i-1];
        wr_b_pipe_r[i]  <= wr_b_pipe_r[i-1];
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.stage     = stage_r;
  assign bus.rd_en     = rd_en_r;
  assign bus.rd_addr_a = rd_addr_a_r;
  assign bus.rd_addr_b = rd_addr_b_r;
  assign bus.tw_addr   = tw_addr_r;
  assign bus.wr_en     = wr_en_pipe_r[PIPE_LAT-1];
  assign bus.wr_addr_a = wr_a_pipe_r[PIPE_LAT-1];
  assign bus.wr_addr_b = wr_b_pipe_r[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl at N_LOG=3, PIPE_LAT=2, with a small
// RAM / twiddle ROM / butterfly model for an end-to-end q=97 transform.
module tb_ntt_stage_ctrl;
  localparam int NL = 3;
  localparam int PL = 2;
  localparam int Q  = 97;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic load_req = 1'b0;
  always #5 clk = ~clk;

  ntt_stage_ctrl_if #(.N_LOG(NL)) bus ();
  ntt_stage_ctrl #(.N_LOG(NL), .PIPE_LAT(PL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // hand-derived butterfly order: stage 0, stage 1, stage 2
  int exp_a  [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
  int exp_b  [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
  int exp_tw [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};

  int init_vec [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
  int ram    [8];
  int tw_tab [8];
  int ra_r, rb_r, w_r, ua_r, prod_r;

  // coefficient RAM, twiddle ROM and butterfly core (1 read + 1 multiply register)
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 8; i++) ram[i] <= init_vec[i];
    end else if (bus.wr_en) begin
      ram[bus.wr_addr_a] <= (ua_r + prod_r) % Q;
      ram[bus.wr_addr_b] <= (ua_r + Q - prod_r) % Q;
    end
    if (bus.rd_en) begin
      ra_r <= ram[bus.rd_addr_a];
      rb_r <= ram[bus.rd_addr_b];
      w_r  <= tw_tab[bus.tw_addr];
    end
    ua_r   <= ra_r;
    prod_r <= (w_r * rb_r) % Q;
  end

  function automatic int modpow(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic int brv3(input int m);
    return ((m & 1) << 2) | (m & 2) | ((m >> 2) & 1);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    #12;
    checks++;
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000)
      $display("FAIL reset_ctrl: busy/done/rd_en/wr_en=%b expected 0000",
               {bus.busy, bus.done, bus.rd_en, bus.wr_en});
    if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000) errors++;
    checks++;
    if (bus.stage !== 3'd0) begin
      errors++;
      $display("FAIL reset_stage: got %0d expected 0", bus.stage);
    end
    checks++;
    if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== 15'd0) begin
      errors++;
      $display("FAIL reset_addr: got %h expected 0",
               {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b});
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // full 19-cycle run checked cycle by cycle; optional start re-pulses mid-run and on done
  task automatic test_run(input bit repulse, input string name);
    bit exp_rd, exp_wr;
    int n, nw, exp_stage;
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      exp_rd    = (c < 18) && ((c % 6) < 4);
      n         = (c / 6) * 4 + (c % 6);
      exp_wr    = (c >= 2) && (c < 20) && (((c - 2) % 6) < 4);
      nw        = ((c - 2) / 6) * 4 + ((c - 2) % 6);
      exp_stage = (c < 18) ? (c / 6) : ((c == 18) ? 2 : 0);
      checks++;
      if (bus.busy !== (c < 19)) begin
        errors++;
        $display("FAIL %s_busy c=%0d: got %b expected %b", name, c, bus.busy, (c < 19));
      end
      checks++;
      if (bus.done !== (c == 18)) begin
        errors++;
        $display("FAIL %s_done c=%0d: got %b expected %b", name, c, bus.done, (c == 18));
      end
      checks++;
      if (bus.stage !== 3'(exp_stage)) begin
        errors++;
        $display("FAIL %s_stage c=%0d: got %0d expected %0d", name, c, bus.stage, exp_stage);
      end
      checks++;
      if (bus.rd_en !== exp_rd) begin
        errors++;
        $display("FAIL %s_rd_en c=%0d: got %b expected %b", name, c, bus.rd_en, exp_rd);
      end
      if (exp_rd) begin
        checks++;
        if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !==
            {3'(exp_a[n]), 3'(exp_b[n]), 3'(exp_tw[n]) }) begin
          errors++;
          $display("FAIL %s_rd_addr c=%0d: got (%0d,%0d) tw %0d expected (%0d,%0d) tw %0d",
                   name, c, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                   exp_a[n], exp_b[n], exp_tw[n]);
        end
      end
      checks++;
      if (bus.wr_en !== exp_wr) begin
        errors++;
        $display("FAIL %s_wr_en c=%0d: got %b expected %b", name, c, bus.wr_en, exp_wr);
      end
      if (exp_wr) begin
        checks++;
        if ({bus.wr_addr_a, bus.wr_addr_b} !== {3'(exp_a[nw]), 3'(exp_b[nw])}) begin
          errors++;
          $display("FAIL %s_wr_addr c=%0d: got (%0d,%0d) expected (%0d,%0d)",
                   name, c, bus.wr_addr_a, bus.wr_addr_b, exp_a[nw], exp_b[nw]);
        end
      end
      bus.start = repulse && ((c == 5) || (c == 18));
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.stage, bus.rd_en} !== {1'b1, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL midrun_precheck: busy/stage/rd_en=%b/%0d/%b expected 1/1/1",
               bus.busy, bus.stage, bus.rd_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
         bus.tw_addr, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} !== 20'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %h expected 0",
               {bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                bus.tw_addr, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b});
    end
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.rd_en, bus.wr_en} !== 3'b000) begin
      errors++;
      $display("FAIL midrun_after_release: busy/rd_en/wr_en=%b expected 000",
               {bus.busy, bus.rd_en, bus.wr_en});
    end
  endtask

  task automatic test_end_to_end();
    int psi, acc, ref_v;
    bit seen;
    psi = 0;
    for (int x = 2; x < Q; x++) if (psi == 0 && modpow(x, 8) == Q - 1) psi = x;
    for (int m = 0; m < 8; m++) tw_tab[m] = modpow(psi, brv3(m));
    @(posedge clk);
    #1 load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL e2e_done_timeout: done not seen within 40 cycles, expected a pulse");
    end
    repeat (3) @(posedge clk);
    #1;
    // output index i holds the evaluation at psi^(2*brv(i)+1)
    for (int i = 0; i < 8; i++) begin
      acc = 0;
      for (int j = 0; j < 8; j++)
        acc = (acc + init_vec[j] * modpow(psi, ((2 * brv3(i) + 1) * j) % 16)) % Q;
      ref_v = acc;
      checks++;
      if (ram[i] !== ref_v) begin
        errors++;
        $display("FAIL e2e_ram[%0d]: got %0d expected %0d", i, ram[i], ref_v);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_run(1'b0, "seq");
    test_run(1'b1, "repulse");
    test_reset_mid_run();
    test_run(1'b0, "after_reset");
    test_end_to_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
